// File: rtl/fetch_ctrl_pkg.sv
// Shared types and encodings for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESET_PC,
      ST_FETCH,
      ST_EXEC,
      ST_HALT
   } state_t;

   // Opcode field, IR[7:6]
   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LDC  = 2'b01;
   localparam logic [1:0] OP_DJNZ = 2'b10;
   localparam logic [1:0] OP_JMP  = 2'b11;

   // Operations understood by module_PC.pc_op_i
   localparam logic [1:0] PC_CLR  = 2'b00;
   localparam logic [1:0] PC_HOLD = 2'b01;
   localparam logic [1:0] PC_INC  = 2'b10;
   localparam logic [1:0] PC_LOAD = 2'b11;

   // Opcode 11 doubles as HALT when the flag bit is set
   function automatic logic is_halt(input logic [1:0] opc, input logic flag);
      return (opc == OP_JMP) && flag;
   endfunction

endpackage

// File: rtl/module_loop_counter.sv
// Loop counter for LDC/DJNZ: loadable, decrements modulo 2^ANCHO.
module module_loop_counter #(
   parameter int ANCHO = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [ANCHO-1:0] load_val,
   output logic [ANCHO-1:0] value,
   output logic             next_is_zero
);

   logic [ANCHO-1:0] dec_val;

   // Decremented value wraps from 0 to all-ones by plain modular arithmetic
   always_comb begin
      dec_val      = value - ANCHO'(1);
      next_is_zero = (dec_val == '0);
   end

   // Counter register: load has priority, decrement otherwise, hold by default
   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (dec) begin
         value <= dec_val;
      end
   end

endmodule

// File: rtl/module_fetch_ctrl.sv
// Instruction-fetch sequencer driving module_PC: fetch, decode, one PC op per instruction.
module module_fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int ANCHO       = 4,
   parameter int ANCHO_INSTR = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic [ANCHO_INSTR-1:0] instr_i,
   output logic [1:0]             pc_op_o,
   output logic [ANCHO-1:0]       pc_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [ANCHO-1:0]       count_o
);

   state_t                 state;
   logic [ANCHO_INSTR-1:0] ir;

   logic [1:0]       in_opc;
   logic             in_flag;
   logic [ANCHO-1:0] in_opnd;
   logic [1:0]       ir_opc;
   logic             ir_flag;

   logic [1:0]       exec_op;
   logic [ANCHO-1:0] exec_tgt;

   logic cnt_load;
   logic cnt_dec;
   logic cnt_next_zero;
   logic unused_bits;

   // Field split of the incoming ROM word and of the latched IR
   always_comb begin
      in_opc  = instr_i[ANCHO_INSTR-1 -: 2];
      in_flag = instr_i[ANCHO_INSTR-3];
      in_opnd = instr_i[ANCHO-1:0];
      ir_opc  = ir[ANCHO_INSTR-1 -: 2];
      ir_flag = ir[ANCHO_INSTR-3];
   end

   // Bits between flag and operand carry no meaning; fold them so they are consumed
   assign unused_bits = ^{instr_i, ir};

   // EXEC outputs are precomputed during FETCH so they leave a register;
   // the counter is stable during FETCH, so its next_is_zero is valid here
   always_comb begin
      exec_op  = PC_INC;
      exec_tgt = '0;
      case (in_opc)
         OP_DJNZ: begin
            if (!cnt_next_zero) begin
               exec_op  = PC_LOAD;
               exec_tgt = in_opnd;
            end
         end
         OP_JMP: begin
            if (is_halt(in_opc, in_flag)) begin
               exec_op = PC_HOLD;
            end else begin
               exec_op  = PC_LOAD;
               exec_tgt = in_opnd;
            end
         end
         default: begin
            exec_op = PC_INC;
         end
      endcase
   end

   // Counter side effects take place at the edge that ends EXEC
   always_comb begin
      cnt_load = (state == ST_EXEC) && (ir_opc == OP_LDC);
      cnt_dec  = (state == ST_EXEC) && (ir_opc == OP_DJNZ);
   end

   module_loop_counter #(
      .ANCHO(ANCHO)
   ) u_loop_counter (
      .clk         (clk),
      .rst         (rst),
      .load        (cnt_load),
      .dec         (cnt_dec),
      .load_val    (ir[ANCHO-1:0]),
      .value       (count_o),
      .next_is_zero(cnt_next_zero)
   );

   // Sequencer FSM with registered outputs; start_i is honoured only in IDLE/HALT
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         ir      <= '0;
         pc_op_o <= PC_HOLD;
         pc_o    <= '0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_HALT: begin
               if (start_i) begin
                  state   <= ST_RESET_PC;
                  pc_op_o <= PC_CLR;
                  pc_o    <= '0;
                  busy_o  <= 1'b1;
                  done_o  <= 1'b0;
               end
            end
            ST_RESET_PC: begin
               state   <= ST_FETCH;
               pc_op_o <= PC_HOLD;
               pc_o    <= '0;
            end
            ST_FETCH: begin
               ir      <= instr_i;
               state   <= ST_EXEC;
               pc_op_o <= exec_op;
               pc_o    <= exec_tgt;
            end
            ST_EXEC: begin
               pc_op_o <= PC_HOLD;
               pc_o    <= '0;
               if (is_halt(ir_opc, ir_flag)) begin
                  state  <= ST_HALT;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end else begin
                  state <= ST_FETCH;
               end
            end
            default: begin
               state   <= ST_IDLE;
               pc_op_o <= PC_HOLD;
               pc_o    <= '0;
               busy_o  <= 1'b0;
               done_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_module_fetch_ctrl.sv
// Bench for module_fetch_ctrl: program-level interpreter model plus directed programs.
module tb_module_fetch_ctrl;
   import fetch_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] instr;
   logic [1:0] pc_op;
   logic [3:0] pc_tgt;
   logic       busy;
   logic       done;
   logic [3:0] count;

   logic [7:0] rom [16];
   logic [3:0] pc_env = 4'd0;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   module_fetch_ctrl #(
      .ANCHO(4),
      .ANCHO_INSTR(8)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start_i(start),
      .instr_i(instr),
      .pc_op_o(pc_op),
      .pc_o   (pc_tgt),
      .busy_o (busy),
      .done_o (done),
      .count_o(count)
   );

   // Stand-in for module_PC plus ROM
   assign instr = rom[pc_env];
   always @(posedge clk) begin
      case (pc_op)
         PC_CLR:  pc_env <= 4'd0;
         PC_INC:  pc_env <= pc_env + 4'd1;
         PC_LOAD: pc_env <= pc_tgt;
         default: pc_env <= pc_env;
      endcase
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- program-level model ----------------
   typedef struct packed {
      logic [1:0] op;
      logic [3:0] tgt;
      logic       busy;
      logic       done;
      logic [3:0] cnt;
   } exp_t;

   exp_t q[$];
   exp_t exp_cur;
   bit   have_exp = 0;
   bit   steady_halt = 0;
   logic [3:0] m_count = 4'd0;

   function automatic exp_t mk(input logic [1:0] op, input logic [3:0] tgt,
                               input logic b, input logic d, input logic [3:0] c);
      exp_t e;
      e.op = op; e.tgt = tgt; e.busy = b; e.done = d; e.cnt = c;
      return e;
   endfunction

   // Interpret the ROM program and append the expected cycle-by-cycle outputs
   task automatic run_program();
      logic [3:0] pc;
      logic [3:0] c;
      logic [3:0] opnd;
      logic [3:0] nc;
      logic [7:0] ins;
      pc = 4'd0;
      c  = m_count;
      q.push_back(mk(2'b00, 4'd0, 1'b1, 1'b0, c));
      for (int n = 0; n < 64; n++) begin
         ins  = rom[pc];
         opnd = ins[3:0];
         q.push_back(mk(2'b01, 4'd0, 1'b1, 1'b0, c));
         case (ins[7:6])
            2'b00: begin
               q.push_back(mk(2'b10, 4'd0, 1'b1, 1'b0, c));
               pc = pc + 4'd1;
            end
            2'b01: begin
               q.push_back(mk(2'b10, 4'd0, 1'b1, 1'b0, c));
               c  = opnd;
               pc = pc + 4'd1;
            end
            2'b10: begin
               nc = c - 4'd1;
               if (nc != 4'd0) begin
                  q.push_back(mk(2'b11, opnd, 1'b1, 1'b0, c));
                  pc = opnd;
               end else begin
                  q.push_back(mk(2'b10, 4'd0, 1'b1, 1'b0, c));
                  pc = pc + 4'd1;
               end
               c = nc;
            end
            default: begin
               if (ins[5]) begin
                  q.push_back(mk(2'b01, 4'd0, 1'b1, 1'b0, c));
                  steady_halt = 1;
                  m_count = c;
                  return;
               end
               q.push_back(mk(2'b11, opnd, 1'b1, 1'b0, c));
               pc = opnd;
            end
         endcase
      end
      steady_halt = 0;
      m_count = c;
   endtask

   // Compare every cycle, then work out what the next cycle must show
   always @(negedge clk) begin
      if (have_exp) begin
         check("pc_op",   pc_op,  exp_cur.op);
         check("pc_o",    pc_tgt, exp_cur.tgt);
         check("busy",    busy,   exp_cur.busy);
         check("done",    done,   exp_cur.done);
         check("count",   count,  exp_cur.cnt);
      end
      if (rst) begin
         q.delete();
         m_count = 4'd0;
         steady_halt = 0;
         exp_cur = mk(2'b01, 4'd0, 1'b0, 1'b0, 4'd0);
         have_exp = 1;
      end else if (have_exp) begin
         if (q.size() == 0 && start) run_program();
         if (q.size() != 0) exp_cur = q.pop_front();
         else exp_cur = mk(2'b01, 4'd0, 1'b0, steady_halt, m_count);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
   endtask

   // Runs the loop program from a start pulse and checks its observable history
   task automatic run_loop_check(input string tag);
      int jumps;
      int body;
      int nchg;
      logic [3:0] prev;
      logic [3:0] seq [4];
      jumps = 0; body = 0; nchg = 0;
      for (int i = 0; i < 4; i++) seq[i] = 4'd0;
      pulse_start();
      prev = count;
      for (int i = 0; i < 24; i++) begin
         if (pc_op == 2'b11 && pc_tgt == 4'd1) jumps++;
         if (pc_op == 2'b10 && pc_env == 4'd1) body++;
         if (count != prev) begin
            if (nchg < 4) seq[nchg] = count;
            nchg++;
            prev = count;
         end
         tick();
      end
      check({tag, "_jumps"}, jumps, 2);
      check({tag, "_body"}, body, 3);
      check({tag, "_nchg"}, nchg, 4);
      check({tag, "_cnt0"}, seq[0], 3);
      check({tag, "_cnt1"}, seq[1], 2);
      check({tag, "_cnt2"}, seq[2], 1);
      check({tag, "_cnt3"}, seq[3], 0);
      check({tag, "_done"}, done, 1);
      check({tag, "_pc"}, pc_env, 3);
   endtask

   initial begin
      logic [1:0] lit [7];
      lit[0] = 2'b00; lit[1] = 2'b01; lit[2] = 2'b10; lit[3] = 2'b01;
      lit[4] = 2'b10; lit[5] = 2'b01; lit[6] = 2'b01;
      clear_rom();

      // reset for two cycles, then idle
      rst = 1'b1;
      tick();
      tick();
      check("rst_op", pc_op, 1);
      check("rst_pc_o", pc_tgt, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_count", count, 0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_op", pc_op, 1);
         check("idle_busy", busy, 0);
      end

      // straight line
      rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'hE0;
      pulse_start();
      for (int i = 0; i < 7; i++) begin
         check("straight_op", pc_op, lit[i]);
         check("straight_done_low", done, 0);
         tick();
      end
      check("straight_done", done, 1);
      check("straight_pc", pc_env, 2);
      tick();
      tick();
      check("straight_hold", done, 1);

      // restart from HALT, with a stray start during FETCH
      pulse_start();
      check("restart_op", pc_op, 0);
      check("restart_done", done, 0);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("fetch_start_op", pc_op, 2);
      for (int i = 0; i < 5; i++) tick();
      check("restart_halt", done, 1);
      check("restart_pc", pc_env, 2);

      // counted loop
      do_reset();
      clear_rom();
      rom[0] = 8'h43; rom[1] = 8'h00; rom[2] = 8'h81; rom[3] = 8'hE0;
      run_loop_check("loop");

      // reset during the first DJNZ EXEC, then rerun
      pulse_start();
      for (int i = 0; i < 6; i++) tick();
      check("mid_pre_op", pc_op, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_op", pc_op, 1);
      check("mid_busy", busy, 0);
      check("mid_count", count, 0);
      run_loop_check("rerun");

      // jump and counter wrap
      do_reset();
      clear_rom();
      rom[0] = 8'hCF; rom[15] = 8'h80;
      pulse_start();
      tick();
      tick();
      check("jmp_op", pc_op, 3);
      check("jmp_tgt", pc_tgt, 15);
      tick();
      tick();
      check("wrap_op", pc_op, 3);
      check("wrap_tgt", pc_tgt, 0);
      tick();
      check("wrap_count", count, 15);
      for (int i = 0; i < 40; i++) begin
         tick();
         check("wrap_no_done", done, 0);
      end
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/module_fetch_ctrl.md
# module_fetch_ctrl

Instruction-fetch sequencer that sits directly upstream of `module_PC` and generates its `pc_op_i` and `pc_i` inputs. It reads the instruction word that the program ROM returns for the current PC value and latches it into an instruction register. It then decodes the word and issues exactly one PC operation per instruction: increment, jump, or hold. Supported control flow is NOP, load loop counter, decrement-and-branch, jump, and halt, under a start/done handshake.

## Interface
- `ANCHO`, 4, PC/address width; must match `module_PC` `ANCHO`.
- `ANCHO_INSTR`, 8, instruction width; opcode in [7:6], flag in [5], operand in [ANCHO-1:0].
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `start_i`  in  1  starts a program run from address 0; sampled in IDLE and HALT only.
- `instr_i`  in  ANCHO_INSTR  ROM data for the address currently on `module_PC.pc_o`, valid in the same cycle.
- `pc_op_o`  out  2  to `module_PC.pc_op_i`: 00 clear PC to 0, 01 hold, 10 increment, 11 load `pc_o`.
- `pc_o`  out  ANCHO  jump target to `module_PC.pc_i`; 0 when `pc_op_o` ≠ 11.
- `busy_o`  out  1  high from RESET_PC through EXEC.
- `done_o`  out  1  high while in HALT.
- `count_o`  out  ANCHO  current loop-counter value.

## Operation
- States: IDLE, RESET_PC, FETCH, EXEC, HALT.
- IDLE: `pc_op_o`=01. When `start_i`=1, go to RESET_PC.
- RESET_PC: `pc_op_o`=00 for one cycle, then go to FETCH.
- FETCH: `pc_op_o`=01. Latch IR←`instr_i` at the clock edge, then go to EXEC.
- EXEC: decode IR, drive one PC operation for exactly one cycle, then go to FETCH. The exception is HALT.
- Opcodes:
  - 00 NOP: `pc_op_o`=10.
  - 01 LDC: counter←IR[ANCHO-1:0]; `pc_op_o`=10.
  - 10 DJNZ: counter←counter−1 (mod 2^ANCHO). If the decremented value ≠ 0, `pc_op_o`=11 and `pc_o`=IR[ANCHO-1:0]. Otherwise `pc_op_o`=10.
  - 11 with IR[5]=0 is JMP: `pc_op_o`=11, `pc_o`=IR[ANCHO-1:0].
  - 11 with IR[5]=1 is HALT: `pc_op_o`=01, go to HALT.
- HALT: `pc_op_o`=01, `done_o`=1. When `start_i`=1, go to RESET_PC (restart). The counter is not cleared on restart.
- `start_i` is ignored in RESET_PC, FETCH, and EXEC.
- DJNZ with counter=0 wraps the counter to 2^ANCHO−1 and jumps. This behaviour is defined, not an error.
- PC increment wrap-around past 2^ANCHO−1 is handled by `module_PC`. This block does not detect it.

## Timing
- All outputs are decoded from registered state and IR only; there is no combinational path from `instr_i` or `start_i` to any output.
- Reset values: state=IDLE, IR=0, counter=0, `pc_op_o`=01, `pc_o`=0, `busy_o`=0, `done_o`=0, `count_o`=0.
- `rst` asserted in any state returns the block to the reset values at the next edge; the counter is also cleared. `rst` takes priority over `start_i`.
- Start latency: the `start_i` edge moves the block to RESET_PC, the next edge is FETCH, and the IR is valid one edge after that.
- Each instruction costs 2 cycles (FETCH + EXEC).
- The counter updates at the edge that ends EXEC, so `count_o` shows the new value in the following FETCH.
- `module_PC` applies `pc_op_o` at the edge that ends EXEC, so `instr_i` in the next FETCH belongs to the new PC.

## Structure
- Package `fetch_ctrl_pkg` contains:
  - state enum `state_t`;
  - opcode localparams `OP_NOP`, `OP_LDC`, `OP_DJNZ`, `OP_JMP`;
  - PC operation localparams `PC_CLR`=00, `PC_HOLD`=01, `PC_INC`=10, `PC_LOAD`=11.
- One sub-module, `module_loop_counter`, parameterized by ANCHO. It takes load, decrement, and load value, and provides the value and a combinational `next_is_zero` flag.
- The FSM, IR, and output decode live in the top level.

## Test plan
- Reset: `rst`=1 for 2 cycles → `pc_op_o`=01, `pc_o`=0, `busy_o`=0, `done_o`=0, `count_o`=0. Then `start_i`=0 for 5 cycles → the block stays in IDLE.
- Straight line: ROM 0:0x00, 1:0x00, 2:0xE0; pulse `start_i`.
  - Required `pc_op_o` sequence: 00, 01, 10, 01, 10, 01, 01, …
  - `done_o`=1 from the 7th cycle after start; the PC stops at 2.
- Loop: ROM 0:0x43, 1:0x00, 2:0x81, 3:0xE0.
  - Body at 1 runs 3 times.
  - DJNZ issues 11/`pc_o`=1 twice, then 10.
  - `count_o` goes 3, 2, 1, 0; the run ends in HALT at PC=3.
- Jump and wrap: ROM 0:0xCF, 15:0x80 (DJNZ 0 with counter=0).
  - `pc_o`=15 with op 11.
  - DJNZ then gives `count_o`=15 and jumps to 0.
  - The sequence repeats; `done_o` never asserts.
- Reset mid-run: assert `rst` during the EXEC of the loop test → next cycle shows `pc_op_o`=01, `busy_o`=0, `count_o`=0. A later start reruns the program from 0 with identical results.
- Restart from HALT: after the straight-line test, pulse `start_i` → RESET_PC (op 00) on the next cycle, `done_o` drops, and the run repeats. `start_i` pulsed during FETCH has no effect.
